ss_column_capture: RTL and testbench
====================================

Name: ss_column_capture

Overview:
- Downstream consumer of the free-running pixel counter in the single-slope column ADC.
- Each column's comparator trips when the ramp crosses the pixel voltage; the block latches the shared counter value for that column.
- After a fixed conversion window it reads the latched codes out one column at a time over a valid/ready stream to the readout path.

Parameters:
- width, 8, counter/code width in bits; matches the counter's width.
- columns, 4, number of comparator columns; at least 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to begin a conversion; ignored unless IDLE.
- count_in  in  width  value from the counter, sampled as-is, no resync.
- comp  in  columns  comparator outputs, synchronous to clk; 1 = ramp has crossed.
- out_data  out  width  latched code of the current column.
- out_col  out  $clog2(columns)  index of the current column.
- out_ovf  out  1  current column never tripped; out_data is all-ones.
- out_valid  out  1  out_data/out_col/out_ovf are valid.
- out_ready  in  1  downstream accepts the word.
- busy  out  1  high in CONVERT and READOUT.
- done  out  1  one-cycle pulse after the last column is accepted.

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE; all latches and latched flags cleared; timer 0; column index 0. All outputs 0: out_data, out_col, out_ovf, out_valid, busy, done.
- Reset mid-CONVERT or mid-READOUT aborts immediately. No done pulse; partial data is discarded.
- FSM states: IDLE, CONVERT, READOUT.
- IDLE -> CONVERT: on start==1.
  - Timer cleared; latched flags cleared.
  - busy rises the cycle after start.
- CONVERT:
  - Lasts exactly 2^width cycles; timer runs 0..2^width-1.
  - Per column i, in any CONVERT cycle where comp[i]==1 and latched[i]==0: code[i] <= count_in of that cycle, latched[i] <= 1.
  - Only the first trip counts; later comp toggles are ignored.
  - A comparator already high in the first CONVERT cycle latches that cycle's count_in.
  - A trip in the final cycle (timer==2^width-1) is latched.
  - On the final cycle: go to READOUT with column index 0.
  - Every column with latched==0 at that point gets code all-ones and ovf=1.
- READOUT:
  - out_valid=1 with out_col=index, out_data=code[index], out_ovf=!latched[index].
  - Outputs are held stable while out_ready==0.
  - A handshake (out_valid && out_ready) at an edge advances the index.
  - Back-to-back transfers are allowed: one word per cycle when out_ready is held high.
  - After the handshake on index columns-1: out_valid=0, done=1 for one cycle, busy=0, state IDLE.
- start in CONVERT or READOUT is ignored; it is not queued.
- start may be asserted the cycle done is high; it begins a new conversion.
- comp is ignored outside CONVERT.
- Timer is width+1 bits wide to avoid wrap ambiguity. The index wraps only via the return to IDLE.
- Latency: start at cycle t gives the first out_valid at cycle t+1+2^width.

Decomposition:
- Package ss_capture_pkg holds:
  - state enum typedef (IDLE, CONVERT, READOUT);
  - localparam function for the index width.
- One sub-module, column_latch (width parameter):
  - inputs clk, reset, clear, en, comp, count_in;
  - outputs code, latched;
  - instantiated columns times via generate.
- Top level holds the FSM, timer, readout mux and handshake.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, then release with start=0. All outputs stay 0 and busy=0 for 20 cycles.
- Basic capture (width=8, columns=4):
  - Stimulus: start; count_in counts from 0 aligned to the first CONVERT cycle; comp[0..3] rise at timer 10, 200, 0 and 255.
  - Expected readout in order: (0,10,ovf0), (1,200,0), (2,0,0), (3,255,0); done pulses once.
- Overflow: comp[1] never rises. Column 1 reads out as 0xFF with out_ovf=1; other columns are unaffected.
- Backpressure:
  - Stimulus: out_ready low for 5 cycles on column 2, then high.
  - Expected: out_data/out_col stable throughout; no column skipped or duplicated; exactly 4 handshakes.
- Glitch and ignored start:
  - Stimulus: comp[0] pulses at timer 5, falls, rises again at 50; start is pulsed during CONVERT.
  - Expected: column 0 reads 5; the conversion length stays 256 cycles.
- Reset mid-READOUT:
  - Stimulus: reset=0 after column 1 is accepted.
  - Expected: out_valid=0 and busy=0 next cycle; no done pulse; a new start yields a fresh full readout.

Source files
------------

// File: rtl/ss_capture_pkg.sv
// ---------------------------------------------------------------------------
// ss_capture_pkg
// Shared definitions for the single-slope column capture block.
//   state_t : top-level FSM states (IDLE, CONVERT, READOUT)
//   idx_w   : width of a column index for a given column count
// ---------------------------------------------------------------------------
package ss_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    READOUT = 2'd2
  } state_t;

  // Column index width. A single column would still need one bit to
  // keep the port legal.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ss_column_capture_column_latch.sv
// ---------------------------------------------------------------------------
// column_latch
// Holds the counter value seen on the first comparator trip of one column
// during a conversion window.
//   clk      : system clock
//   reset    : synchronous, active-low reset
//   clear    : forget the previous conversion (new conversion starting)
//   en       : conversion window is open
//   comp     : comparator output for this column, 1 = ramp has crossed
//   count_in : shared counter value
//   code     : latched counter value
//   latched  : a trip has been captured since the last clear
// ---------------------------------------------------------------------------
module column_latch #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic             comp,
  input  logic [width-1:0] count_in,
  output logic [width-1:0] code,
  output logic             latched
);

  logic [width-1:0] r_code;
  logic             r_latched;

  // Only the first trip in a window is kept; later comparator activity
  // (glitches, chatter) cannot overwrite it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_code    <= '0;
      r_latched <= 1'b0;
    end else if (clear) begin
      r_code    <= '0;
      r_latched <= 1'b0;
    end else if (en && comp && !r_latched) begin
      r_code    <= count_in;
      r_latched <= 1'b1;
    end
  end

  assign code    = r_code;
  assign latched = r_latched;

endmodule

// File: rtl/ss_column_capture.sv
// ---------------------------------------------------------------------------
// ss_column_capture
// Captures the shared ramp counter value for each comparator column during a
// 2^width-cycle conversion window, then streams the codes out one column per
// valid/ready handshake.
//   clk       : system clock
//   reset     : synchronous, active-low reset
//   start     : one-cycle conversion request, honoured only when idle
//   count_in  : shared counter value, sampled as-is
//   comp      : per-column comparator outputs, synchronous to clk
//   out_data  : code of the current column (all-ones if it never tripped)
//   out_col   : index of the current column
//   out_ovf   : current column never tripped
//   out_valid : out_data/out_col/out_ovf are valid
//   out_ready : downstream accepts the word
//   busy      : conversion or readout in progress
//   done      : one-cycle pulse after the last column is accepted
// ---------------------------------------------------------------------------
module ss_column_capture
  import ss_capture_pkg::*;
#(
  parameter int width   = 8,
  parameter int columns = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [width-1:0]            count_in,
  input  logic [columns-1:0]          comp,
  output logic [width-1:0]            out_data,
  output logic [idx_w(columns)-1:0]   out_col,
  output logic                        out_ovf,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        busy,
  output logic                        done
);

  localparam int IW = idx_w(columns);
  // Timer carries one extra bit so the final count is unambiguous.
  localparam logic [width:0]  LAST_TICK = {1'b0, {width{1'b1}}};
  localparam logic [IW-1:0]   LAST_COL  = IW'(columns - 1);

  state_t           r_state;
  logic [width:0]   r_timer;
  logic [IW-1:0]    r_idx;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;

  logic             w_start_acc;
  logic             w_conv;
  logic             w_last_tick;
  logic             w_hs;
  logic             w_last_col;
  logic [width-1:0] w_code [columns];
  logic [columns-1:0] w_latched;

  assign w_start_acc = (r_state == IDLE) && start;
  assign w_conv      = (r_state == CONVERT);
  assign w_last_tick = w_conv && (r_timer == LAST_TICK);
  assign w_hs        = r_valid && out_ready;
  assign w_last_col  = (r_idx == LAST_COL);

  // Per-column capture; a start accepted in IDLE clears every latch so a
  // new conversion never sees stale trips.
  for (genvar g = 0; g < columns; g++) begin : g_col
    column_latch #(.width(width)) u_latch (
      .clk      (clk),
      .reset    (reset),
      .clear    (w_start_acc),
      .en       (w_conv),
      .comp     (comp[g]),
      .count_in (count_in),
      .code     (w_code[g]),
      .latched  (w_latched[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_timer <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= CONVERT;
            r_timer <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b1;
          end
        end
        CONVERT: begin
          r_timer <= r_timer + 1'b1;
          // The latches sample comp on this same edge, so a trip in the
          // final cycle is already captured when READOUT begins.
          if (w_last_tick) begin
            r_state <= READOUT;
            r_idx   <= '0;
            r_valid <= 1'b1;
          end
        end
        READOUT: begin
          if (w_hs) begin
            if (w_last_col) begin
              r_state <= IDLE;
              r_idx   <= '0;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Readout mux: a column that never tripped reports all-ones with ovf.
  // Data outputs are forced to zero whenever no word is being offered.
  always_comb begin
    out_data = '0;
    out_ovf  = 1'b0;
    if (r_valid) begin
      out_data = w_latched[r_idx] ? w_code[r_idx] : {width{1'b1}};
      out_ovf  = !w_latched[r_idx];
    end
  end

  assign out_col   = r_idx;
  assign out_valid = r_valid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_ss_column_capture.sv
module tb_ss_column_capture;

  localparam int W     = 8;
  localparam int C     = 4;
  localparam int NEVER = -1;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] count_in = '0;
  logic [C-1:0] comp = '0;
  logic [W-1:0] out_data;
  logic [1:0]   out_col;
  logic         out_ovf;
  logic         out_valid;
  logic         busy;
  logic         done;

  always #5 clk = ~clk;

  ss_column_capture #(.width(W), .columns(C)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .count_in  (count_in),
    .comp      (comp),
    .out_data  (out_data),
    .out_col   (out_col),
    .out_ovf   (out_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  typedef struct packed {
    logic [1:0]   col;
    logic [W-1:0] data;
    logic         ovf;
  } word_t;

  word_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    hs_cnt = 0;
  int    done_cnt = 0;
  int    cyc = 0;
  int    start_cyc = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void push(input logic [1:0] c, input logic [W-1:0] d, input logic o);
    word_t e;
    e = {c, d, o};
    exp_q.push_back(e);
  endfunction

  // Monitor / scoreboard
  word_t w_now;
  word_t prev_w = '0;
  logic  prev_stall = 1'b0;
  logic  prev_valid = 1'b0;

  always @(negedge clk) begin
    w_now = {out_col, out_data, out_ovf};
    if (prev_stall)
      check("hold_while_stalled", {out_valid, w_now}, {1'b1, prev_w});
    if (out_valid === 1'b1 && prev_valid !== 1'b1)
      check("first_valid_latency", cyc - start_cyc, 257);
    if (out_valid === 1'b1 && out_ready === 1'b1 && reset === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_word: actual %0h required none", w_now);
      end else begin
        word_t e;
        e = exp_q.pop_front();
        check("readout_word", w_now, e);
      end
      hs_cnt++;
    end
    if (done === 1'b1) begin
      done_cnt++;
      check("done_cycle_valid_busy", {out_valid, busy}, 0);
    end
    prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0) && (reset === 1'b1);
    prev_w     = w_now;
    prev_valid = out_valid;
  end

  task automatic run_conv(input int t0, input int t1, input int t2, input int t3,
                          input bit glitch, input bit pulse_start);
    int trip[C];
    trip = '{t0, t1, t2, t3};
    hs_cnt   = 0;
    done_cnt = 0;
    out_ready = 1'b0;
    comp = '0;
    @(posedge clk); #1;
    check("busy_before_start", busy, 0);
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 256; k++) begin
      if (k == 0) check("busy_after_start", busy, 1);
      if (k == 255) check("no_valid_in_convert", out_valid, 0);
      count_in = W'(k);
      for (int i = 0; i < C; i++)
        comp[i] = (trip[i] != NEVER) && (k >= trip[i]);
      if (glitch) comp[0] = (k == 5) || (k >= 50);
      start = pulse_start && (k == 100);
      @(posedge clk); #1;
    end
    start = 1'b0;
    // comp activity after the window must not affect any code
    comp = '1;
    count_in = 8'hA5;
  endtask

  task automatic readout(input int bp_col, input int abort_after);
    int stall;
    bit fin;
    stall = 0;
    fin = 1'b0;
    for (int c = 0; c < 100 && !fin; c++) begin
      if (abort_after > 0 && hs_cnt == abort_after) begin
        out_ready = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt, 0);
        exp_q.delete();
        fin = 1'b1;
      end else if (done_cnt > 0) begin
        fin = 1'b1;
      end else begin
        if (out_valid && out_col == bp_col && stall < 5) begin
          out_ready = 1'b0;
          stall++;
        end else begin
          out_ready = 1'b1;
        end
        @(posedge clk); #1;
      end
    end
    if (!fin) begin
      n_cmp++;
      n_bad++;
      $display("FAIL readout_timeout: actual no done required done within 100 cycles");
    end
    comp = '0;
    if (abort_after == 0) begin
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("handshake_count", hs_cnt, 4);
      check("done_pulses", done_cnt, 1);
      check("queue_drained", exp_q.size(), 0);
      check("idle_after_done", busy, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset then idle
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check("idle_outputs", {out_data, out_col, out_ovf, out_valid, busy, done}, 0);
      @(posedge clk); #1;
    end

    // Basic capture, including trips in the first and final cycles
    push(2'd0, 8'd10, 1'b0);
    push(2'd1, 8'd200, 1'b0);
    push(2'd2, 8'd0, 1'b0);
    push(2'd3, 8'd255, 1'b0);
    run_conv(10, 200, 0, 255, 1'b0, 1'b0);
    readout(NEVER, 0);

    // Overflow on column 1
    push(2'd0, 8'd30, 1'b0);
    push(2'd1, 8'hFF, 1'b1);
    push(2'd2, 8'd128, 1'b0);
    push(2'd3, 8'd7, 1'b0);
    run_conv(30, NEVER, 128, 7, 1'b0, 1'b0);
    readout(NEVER, 0);

    // Backpressure on column 2
    push(2'd0, 8'd1, 1'b0);
    push(2'd1, 8'd2, 1'b0);
    push(2'd2, 8'd3, 1'b0);
    push(2'd3, 8'd4, 1'b0);
    run_conv(1, 2, 3, 4, 1'b0, 1'b0);
    readout(2, 0);

    // Glitching comparator and start pulsed mid-conversion
    push(2'd0, 8'd5, 1'b0);
    push(2'd1, 8'd60, 1'b0);
    push(2'd2, 8'd70, 1'b0);
    push(2'd3, 8'd80, 1'b0);
    run_conv(0, 60, 70, 80, 1'b1, 1'b1);
    readout(NEVER, 0);

    // Reset after column 1 is accepted
    push(2'd0, 8'd11, 1'b0);
    push(2'd1, 8'd22, 1'b0);
    push(2'd2, 8'd33, 1'b0);
    push(2'd3, 8'd44, 1'b0);
    run_conv(11, 22, 33, 44, 1'b0, 1'b0);
    readout(NEVER, 2);

    // Fresh conversion after abort: column 0 must not keep its old code
    push(2'd0, 8'hFF, 1'b1);
    push(2'd1, 8'd100, 1'b0);
    push(2'd2, 8'd101, 1'b0);
    push(2'd3, 8'd102, 1'b0);
    run_conv(NEVER, 100, 101, 102, 1'b0, 1'b0);
    readout(NEVER, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
